// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the parametrised sequential MAC.
//   state_e    : controller states (IDLE, RUN, DRAIN, FINISH)
//   clog2()    : ceiling log2 helper used to size the term counter
//   DEF_*      : default parameter values for the MAC and its interface
package mac_pkg;

   localparam int unsigned DEF_DW     = 4;
   localparam int unsigned DEF_N      = 8;
   localparam int unsigned DEF_ACCW   = 12;
   localparam bit          DEF_SIGNED = 1'b0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_e;

   // Ceiling log2, never narrower than one bit so a counter width is always legal.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/mac_seq_p_if.sv
// mac_seq_p_if: operand stream handshake for mac_seq_p.
//   a, b      : operand pair, DW bits each
//   in_valid  : producer has a pair on a/b
//   in_ready  : MAC accepts the pair this cycle
// master = operand producer, slave = MAC.
interface mac_seq_p_if
   import mac_pkg::*;
#(
   parameter int unsigned DW = DEF_DW
);

   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          in_valid;
   logic          in_ready;

   modport master (output a, b, in_valid, input  in_ready);
   modport slave  (input  a, b, in_valid, output in_ready);

endinterface

// File: rtl/mac_ctrl_p.sv
// mac_ctrl_p: controller for mac_seq_p (FSM + term counter).
//   clk, rst  : clock, synchronous active-low reset
//   go        : start request, honoured only in IDLE
//   in_valid  : operand pair present
//   in_ready  : decoded from state (RUN)
//   ld_m      : capture product of the pair accepted this cycle
//   ld_acc    : product register holds an unaccumulated product (registered)
//   clr       : clear datapath run state at start
//   ld_out    : publish accumulator to the outputs (FINISH)
//   cmp       : term counter has reached N
module mac_ctrl_p
   import mac_pkg::*;
#(
   parameter int unsigned N = DEF_N
) (
   input  logic clk,
   input  logic rst,
   input  logic go,
   input  logic in_valid,
   output logic in_ready,
   output logic ld_m,
   output logic ld_acc,
   output logic clr,
   output logic ld_out,
   output logic cmp
);

   localparam int unsigned CW = clog2(N + 1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          ld_acc_q;
   logic          accept;

   assign in_ready = (state_q == RUN);
   assign accept   = in_ready & in_valid;
   assign ld_m     = accept;
   assign clr      = (state_q == IDLE) & go;
   assign ld_out   = (state_q == FINISH);
   assign cmp      = (cnt_q == CW'(N));
   assign ld_acc   = ld_acc_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ld_acc_q <= 1'b0;
      end else begin
         // Product-valid bit: one cycle behind each accepted pair.
         ld_acc_q <= accept;
         case (state_q)
            IDLE: begin
               if (go) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(N - 1)) state_q <= DRAIN;
               end
            end
            DRAIN:   state_q <= FINISH;
            FINISH:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mac_seq_p.sv
// mac_seq_p: parametrised sequential multiply-accumulate engine.
//   clk, rst : clock, synchronous active-low reset
//   go       : start a run of N operand pairs (sampled in IDLE)
//   s        : operand stream (a, b, in_valid, in_ready), slave side
//   out      : final ACCW-bit sum, held until the next completion
//   done     : one-cycle pulse, out/ovf valid
//   ovf      : overflow seen anywhere during the last run
// Datapath lives here (product reg, accumulator, overflow, output regs);
// sequencing is in mac_ctrl_p.
module mac_seq_p
   import mac_pkg::*;
#(
   parameter int unsigned DW     = DEF_DW,
   parameter int unsigned N      = DEF_N,
   parameter int unsigned ACCW   = DEF_ACCW,
   parameter bit          SIGNED = DEF_SIGNED
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            go,
   mac_seq_p_if.slave      s,
   output logic [ACCW-1:0] out,
   output logic            done,
   output logic            ovf
);

   logic            ld_m, ld_acc, clr, ld_out, cmp;
   logic [2*DW-1:0] prod_q, prod_d;
   logic [ACCW-1:0] acc_q, prod_ext, sum_d, out_q;
   logic            carry, step_ovf, publish;
   logic            ovf_run_q, ovf_q, done_q;

   mac_ctrl_p #(
      .N (N)
   ) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .in_valid (s.in_valid),
      .in_ready (s.in_ready),
      .ld_m     (ld_m),
      .ld_acc   (ld_acc),
      .clr      (clr),
      .ld_out   (ld_out),
      .cmp      (cmp)
   );

   always_comb begin
      prod_d   = '0;
      prod_ext = '0;
      if (SIGNED) begin
         prod_d   = (2*DW)'($signed(s.a)) * (2*DW)'($signed(s.b));
         prod_ext = ACCW'($signed(prod_q));
      end else begin
         prod_d   = (2*DW)'(s.a) * (2*DW)'(s.b);
         prod_ext = ACCW'(prod_q);
      end
      {carry, sum_d} = {1'b0, acc_q} + {1'b0, prod_ext};
      if (SIGNED)
         step_ovf = (acc_q[ACCW-1] == prod_ext[ACCW-1]) && (sum_d[ACCW-1] != acc_q[ACCW-1]);
      else
         step_ovf = carry;
   end

   // cmp qualifies the publish so a run cut short can never present a sum.
   assign publish = ld_out & cmp;

   always_ff @(posedge clk) begin
      if (!rst) begin
         prod_q    <= '0;
         acc_q     <= '0;
         ovf_run_q <= 1'b0;
         out_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if (clr) begin
            prod_q    <= '0;
            acc_q     <= '0;
            ovf_run_q <= 1'b0;
         end else begin
            if (ld_m) prod_q <= prod_d;
            if (ld_acc) begin
               acc_q     <= sum_d;
               ovf_run_q <= ovf_run_q | step_ovf;
            end
         end
         done_q <= publish;
         if (publish) begin
            out_q <= acc_q;
            ovf_q <= ovf_run_q;
         end
      end
   end

   assign out  = out_q;
   assign done = done_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_mac_seq_p.sv
// tb_mac_seq_p: four mac_seq_p instances (default, signed, ACCW=10, N=1)
// exercised with a vector table, hand-written corner sequences and random runs
// scored against an arithmetic reference model.
module tb_mac_seq_p;

   logic        clk = 1'b0;
   logic        rst;
   logic        go_v  [4];
   logic [3:0]  a_v   [4];
   logic [3:0]  b_v   [4];
   logic        iv_v  [4];
   logic        rdy_v [4];
   logic        done_v[4];
   logic        ovf_v [4];
   logic [11:0] out_v [4];
   logic [9:0]  out2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mac_seq_p_if #(.DW(4)) if0 ();
   mac_seq_p_if #(.DW(4)) if1 ();
   mac_seq_p_if #(.DW(4)) if2 ();
   mac_seq_p_if #(.DW(4)) if3 ();

   assign if0.a = a_v[0]; assign if0.b = b_v[0]; assign if0.in_valid = iv_v[0]; assign rdy_v[0] = if0.in_ready;
   assign if1.a = a_v[1]; assign if1.b = b_v[1]; assign if1.in_valid = iv_v[1]; assign rdy_v[1] = if1.in_ready;
   assign if2.a = a_v[2]; assign if2.b = b_v[2]; assign if2.in_valid = iv_v[2]; assign rdy_v[2] = if2.in_ready;
   assign if3.a = a_v[3]; assign if3.b = b_v[3]; assign if3.in_valid = iv_v[3]; assign rdy_v[3] = if3.in_ready;
   assign out_v[2] = {2'b00, out2};

   mac_seq_p #(.DW(4), .N(8), .ACCW(12), .SIGNED(1'b0)) d0 (
      .clk(clk), .rst(rst), .go(go_v[0]), .s(if0), .out(out_v[0]), .done(done_v[0]), .ovf(ovf_v[0]));
   mac_seq_p #(.DW(4), .N(8), .ACCW(12), .SIGNED(1'b1)) d1 (
      .clk(clk), .rst(rst), .go(go_v[1]), .s(if1), .out(out_v[1]), .done(done_v[1]), .ovf(ovf_v[1]));
   mac_seq_p #(.DW(4), .N(8), .ACCW(10), .SIGNED(1'b0)) d2 (
      .clk(clk), .rst(rst), .go(go_v[2]), .s(if2), .out(out2), .done(done_v[2]), .ovf(ovf_v[2]));
   mac_seq_p #(.DW(4), .N(1), .ACCW(12), .SIGNED(1'b0)) d3 (
      .clk(clk), .rst(rst), .go(go_v[3]), .s(if3), .out(out_v[3]), .done(done_v[3]), .ovf(ovf_v[3]));

   typedef struct {
      int    idx;
      int    kind;     // 0: constant pair av x bv, 1: ramp 1x1 .. NxN
      int    av;
      int    bv;
      bit    gaps;
      int    exp_out;
      bit    exp_ovf;
      int    exp_lat;  // 0: latency not checked
      string name;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int nterms(input int idx);
      return (idx == 3) ? 1 : 8;
   endfunction

   // Reference: plain integer sum, wrapped to the accumulator width, with overflow
   // flagged whenever a partial sum leaves the representable range.
   function automatic void model(input int idx, input int pa[$], input int pb[$],
                                 output int eo, output bit ev);
      longint acc, p, md, hi, lo;
      int     x, y;
      bit     sgn;
      int     accw;
      sgn  = (idx == 1);
      accw = (idx == 2) ? 10 : 12;
      md   = longint'(1) << accw;
      hi   = md / 2 - 1;
      lo   = -(md / 2);
      acc  = 0;
      ev   = 1'b0;
      foreach (pa[i]) begin
         x = pa[i];
         y = pb[i];
         if (sgn) begin
            if (x >= 8) x -= 16;
            if (y >= 8) y -= 16;
         end
         p = longint'(x * y);
         acc += p;
         if (sgn) begin
            if (acc > hi) begin ev = 1'b1; acc -= md; end
            else if (acc < lo) begin ev = 1'b1; acc += md; end
         end else if (acc >= md) begin
            ev = 1'b1;
            acc -= md;
         end
      end
      if (acc < 0) acc += md;
      eo = int'(acc);
   endfunction

   // Called at a negedge; returns at the negedge after the done edge.
   task automatic run_pairs(input int idx, input int pa[$], input int pb[$],
                            input bit gaps, input bit rnd_valid, input bit go_mid,
                            input bit keep_go, input bit started,
                            output int lat, output int got_out, output bit got_ovf,
                            output int acc_n);
      int i   = 0;
      int cyc = 0;
      bit fin = 1'b0;
      int n   = pa.size();
      lat = -1; got_out = 0; got_ovf = 1'b0; acc_n = 0;
      if (gaps) begin
         for (int k = 0; k < 2; k++) begin
            iv_v[idx] = 1'b1; a_v[idx] = 4'hF; b_v[idx] = 4'hF;
            if (rdy_v[idx]) acc_n++;
            @(negedge clk);
         end
      end
      if (!started) go_v[idx] = 1'b1;
      while (!fin && cyc < 300) begin
         if (i < n && (!gaps || (cyc % 2) == 0) && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
            iv_v[idx] = 1'b1; a_v[idx] = 4'(pa[i]); b_v[idx] = 4'(pb[i]);
         end else begin
            iv_v[idx] = (i >= n);
            a_v[idx]  = 4'($urandom_range(0, 15));
            b_v[idx]  = 4'($urandom_range(0, 15));
         end
         if (rdy_v[idx] && iv_v[idx]) begin
            acc_n++;
            if (i < n) i++;
         end
         @(posedge clk);
         cyc++;
         #1;
         if (done_v[idx]) begin
            fin     = 1'b1;
            lat     = cyc;
            got_out = int'(out_v[idx]);
            got_ovf = ovf_v[idx];
         end
         @(negedge clk);
         go_v[idx] = keep_go || (go_mid && cyc == 3);
      end
      iv_v[idx] = 1'b0;
      chk($sformatf("done_seen_d%0d", idx), longint'(fin), 1);
   endtask

   task automatic pulse_end(input int idx, input string name);
      @(posedge clk);
      #1;
      chk({name, "_done_single"}, longint'(done_v[idx]), 0);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, got, acc_n, eo, idx;
      bit gov, ev;
      int pa[$], pb[$];

      tbl[0] = '{0, 0, 15, 15, 1'b0, 1800,  1'b0, 11, "ufull"};
      tbl[1] = '{1, 0,  8,  7, 1'b0, 'hE40, 1'b0, 11, "sneg"};
      tbl[2] = '{1, 0,  8,  8, 1'b0, 512,   1'b0, 11, "spos"};
      tbl[3] = '{2, 0, 15, 15, 1'b0, 776,   1'b1, 11, "uovf"};
      tbl[4] = '{2, 0,  1,  1, 1'b0, 8,     1'b0, 11, "uovf_clear"};
      tbl[5] = '{0, 1,  0,  0, 1'b1, 204,   1'b0, 0,  "gaps"};
      tbl[6] = '{3, 0, 15, 15, 1'b0, 225,   1'b0, 4,  "n1"};

      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         go_v[k] = 1'b0; iv_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("reset_out_d%0d", k),  longint'(out_v[k]), 0);
         chk($sformatf("reset_done_d%0d", k), longint'(done_v[k]), 0);
         chk($sformatf("reset_ovf_d%0d", k),  longint'(ovf_v[k]), 0);
         chk($sformatf("reset_rdy_d%0d", k),  longint'(rdy_v[k]), 0);
      end
      rst = 1'b1;
      @(negedge clk);

      foreach (tbl[t]) begin
         pa.delete(); pb.delete();
         for (int i = 0; i < nterms(tbl[t].idx); i++) begin
            if (tbl[t].kind == 0) begin pa.push_back(tbl[t].av); pb.push_back(tbl[t].bv); end
            else begin pa.push_back(i + 1); pb.push_back(i + 1); end
         end
         run_pairs(tbl[t].idx, pa, pb, tbl[t].gaps, 1'b0, 1'b0, 1'b0, 1'b0, lat, got, gov, acc_n);
         chk({tbl[t].name, "_out"}, got, tbl[t].exp_out);
         chk({tbl[t].name, "_ovf"}, longint'(gov), longint'(tbl[t].exp_ovf));
         chk({tbl[t].name, "_accepts"}, acc_n, pa.size());
         if (tbl[t].exp_lat != 0) chk({tbl[t].name, "_latency"}, lat, tbl[t].exp_lat);
         pulse_end(tbl[t].idx, tbl[t].name);
      end

      // go pulsed mid-run is ignored
      pa.delete(); pb.delete();
      for (int i = 0; i < 8; i++) begin pa.push_back(15); pb.push_back(15); end
      run_pairs(0, pa, pb, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, lat, got, gov, acc_n);
      chk("gomid_out", got, 1800);
      chk("gomid_latency", lat, 11);
      pulse_end(0, "gomid");

      // go held through FINISH restarts immediately after done
      pa.delete(); pb.delete();
      for (int i = 0; i < 8; i++) begin pa.push_back(2); pb.push_back(3); end
      run_pairs(0, pa, pb, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, lat, got, gov, acc_n);
      chk("held_first_out", got, 48);
      @(posedge clk);
      #1;
      chk("held_restart_rdy", longint'(rdy_v[0]), 1);
      chk("held_restart_done_low", longint'(done_v[0]), 0);
      @(negedge clk);
      go_v[0] = 1'b0;
      pa.delete(); pb.delete();
      for (int i = 0; i < 8; i++) begin pa.push_back(3); pb.push_back(3); end
      run_pairs(0, pa, pb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lat, got, gov, acc_n);
      chk("held_second_out", got, 72);
      chk("held_second_accepts", acc_n, 8);
      pulse_end(0, "held_second");

      // reset mid-run discards the partial sum and clears published results
      pa.delete(); pb.delete();
      for (int i = 0; i < 8; i++) begin pa.push_back(15); pb.push_back(15); end
      run_pairs(2, pa, pb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, got, gov, acc_n);
      chk("pre_rst_ovf_d2", longint'(gov), 1);
      pulse_end(2, "pre_rst");
      go_v[0] = 1'b1;
      @(negedge clk);
      go_v[0] = 1'b0;
      iv_v[0] = 1'b1; a_v[0] = 4'd5; b_v[0] = 4'd5;
      repeat (4) @(negedge clk);
      iv_v[0] = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_out", longint'(out_v[0]), 0);
      chk("rst_mid_done", longint'(done_v[0]), 0);
      chk("rst_mid_rdy", longint'(rdy_v[0]), 0);
      chk("rst_mid_out_d2", longint'(out_v[2]), 0);
      chk("rst_mid_ovf_d2", longint'(ovf_v[2]), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pa.delete(); pb.delete();
      for (int i = 0; i < 8; i++) begin pa.push_back(int'($urandom_range(0, 15))); pb.push_back(int'($urandom_range(0, 15))); end
      model(0, pa, pb, eo, ev);
      run_pairs(0, pa, pb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, got, gov, acc_n);
      chk("post_rst_out", got, eo);
      chk("post_rst_latency", lat, 11);
      pulse_end(0, "post_rst");

      // random operands and random in_valid gaps on every instance
      for (int r = 0; r < 16; r++) begin
         idx = r % 4;
         pa.delete(); pb.delete();
         for (int i = 0; i < nterms(idx); i++) begin
            pa.push_back(int'($urandom_range(0, 15)));
            pb.push_back(int'($urandom_range(0, 15)));
         end
         model(idx, pa, pb, eo, ev);
         run_pairs(idx, pa, pb, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lat, got, gov, acc_n);
         chk($sformatf("rnd%0d_d%0d_out", r, idx), got, eo);
         chk($sformatf("rnd%0d_d%0d_ovf", r, idx), longint'(gov), longint'(ev));
         chk($sformatf("rnd%0d_d%0d_accepts", r, idx), acc_n, pa.size());
         pulse_end(idx, $sformatf("rnd%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_seq_p.md
# mac_seq_p

Parametrised sequential multiply-accumulate engine. The next generation of the team's fixed 4-bit/12-bit MAC: operand width, term count, accumulator width and signedness are parameters, and operand pairs stream in through a valid/ready handshake. It keeps the controller/datapath split and the `go`/`done` top-level protocol, so it drops into the same system slot as the current MAC.

## Interface
- `DW`, 4: operand width, in bits.
- `N`, 8: operand pairs per accumulation, ≥1.
- `ACCW`, 12: accumulator and output width, ≥2·DW.
- `SIGNED`, 0: 1 = two's-complement operands and accumulator; 0 = unsigned.

- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `go`, in, 1: start request, sampled only in IDLE.
- `a`, in, DW: operand A.
- `b`, in, DW: operand B.
- `in_valid`, in, 1: an operand pair is present on `a`/`b`.
- `in_ready`, out, 1: the block accepts a pair this cycle.
- `out`, out, ACCW: final accumulated sum, held until the next completion.
- `done`, out, 1: one-cycle pulse; `out` is valid this cycle.
- `ovf`, out, 1: sticky overflow flag for the last run, valid with `done`.

## Operation
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE:
  - `in_ready`=0.
  - `go`=1 moves to RUN, clears the accumulator, the product register, the term counter and the internal overflow flag.
  - `out` and `ovf` are not touched.
- RUN:
  - `in_ready`=1.
  - A pair is accepted on each edge where `in_valid`&&`in_ready`.
  - The product `a*b` (2·DW bits, signed or unsigned per `SIGNED`) is registered and a product-valid bit is set.
  - The term counter (width clog2(N+1)) increments on each accepted pair.
  - The Nth accepted pair moves the FSM to DRAIN. `in_ready` is 0 from the next cycle on.
- Accumulation: each cycle the product-valid bit is set, the product is sign- or zero-extended to ACCW and added to the accumulator.
- DRAIN: the last product is added. Then go to FINISH.
- FINISH: `out`←accumulator, `ovf`←internal flag, `done`=1 for this cycle. Then go to IDLE.
- Arithmetic:
  - The sum wraps modulo 2^ACCW.
  - Unsigned: overflow is the carry out of bit ACCW-1.
  - Signed: overflow is operands of equal sign giving a result of the opposite sign.
  - The internal flag is sticky for the whole run.
- Boundary conditions:
  - `go` in RUN, DRAIN or FINISH is ignored; no restart and no queuing.
  - `in_valid` in IDLE, DRAIN or FINISH is ignored.
  - Gaps in `in_valid` stall the run indefinitely; no timeout.
  - With N=1: one accept, then DRAIN, then FINISH.
  - `go` held high through FINISH starts a new run on the cycle after `done` (IDLE samples it).
- Reset (`rst`=0 at an edge), in any state including mid-run:
  - FSM returns to IDLE.
  - `out`=0, `done`=0, `ovf`=0, `in_ready`=0.
  - Accumulator, product register, product-valid bit and counter are all cleared.
  - A partial sum is discarded.

## Timing
- `go` sampled at edge g: RUN from g; `in_ready`=1 in the cycle after g.
- Nth pair accepted at edge k:
  - Product registered at k.
  - Accumulator final at k+1 (DRAIN).
  - `out` and `done` registered at k+2.
  - `done` is high for exactly one cycle, between k+2 and k+3.
- Minimum run: N+3 cycles from `go` to `done` with `in_valid` held high.
- Throughput: one pair per cycle in RUN.
- All outputs are registered. There is no combinational path from inputs to outputs, except `in_ready`, which is decoded from the state register only.

## Structure
- Package `mac_pkg`:
  - FSM state enum (IDLE, RUN, DRAIN, FINISH).
  - A `clog2` helper function.
  - Default parameter constants.
- Sub-module `mac_ctrl_p`:
  - Contains the FSM and the term counter.
  - Outputs the load/enable strobes: `ld_m`, `ld_acc`, `clr`, `ld_out`, and `cmp` (counter == N).
- The datapath (product register, accumulator, overflow logic, output registers) stays in `mac_seq_p`, mirroring the existing controller/datapath split.

## Test plan
- Unsigned full-scale, defaults, 8 pairs of 15×15, `in_valid` continuous:
  - `out`=1800, `ovf`=0.
  - `done` exactly 11 cycles after the `go` edge; single pulse.
- Signed, `SIGNED`=1, ACCW=12, 8 pairs of (−8)×7:
  - `out`=12'hE40 (−448), `ovf`=0.
  - Follow with 8 pairs of (−8)×(−8): `out`=512, `ovf`=0.
- Overflow, ACCW=10 unsigned, 8 pairs of 15×15:
  - `out`=776 (1800 mod 1024), `ovf`=1.
  - A following run of 8 pairs of 1×1 gives `out`=8, `ovf`=0.
- Handshake gaps, pairs 1×1…8×8 with `in_valid` toggling every other cycle and extra `in_valid` pulses in IDLE and DRAIN:
  - `out`=204.
  - Exactly 8 accepts counted.
- Control corner cases:
  - `go` pulsed mid-RUN: no restart, result unchanged.
  - `rst`=0 after 4 pairs: the following cycle `out`=0, `done`=0, `in_ready`=0.
  - A fresh run then gives the correct sum.
- N=1, 15×15: `out`=225, `done` exactly 4 cycles after the `go` edge.
